// File: rtl/change_dispenser.sv
// Coin return path: latches the customer balance and pays it out greedily, one
// coin per accepted cycle, skipping empty tubes, then reports any unpaid residual.
module change_dispenser #(
    parameter int NUM_COINS = 3,
    parameter int COIN_VAL0 = 100,
    parameter int COIN_VAL1 = 500,
    parameter int COIN_VAL2 = 1000,
    parameter int W         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_trigger_return,
    input  logic [W-1:0]         i_wait_time,
    input  logic [W-1:0]         i_total,
    input  logic [NUM_COINS-1:0] i_stock_empty,
    input  logic                 i_coin_ready,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic                 o_debit,
    output logic [W-1:0]         o_debit_amt,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [W-1:0]         o_residual
);
    localparam int SW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t               r_state, w_state_next;
    logic [W-1:0]         r_remaining, w_remaining_next;
    logic [NUM_COINS-1:0] r_return_coin, w_return_coin_next;
    logic                 r_debit, w_debit_next;
    logic [W-1:0]         r_debit_amt, w_debit_amt_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;
    logic [W-1:0]         r_residual, w_residual_next;

    logic [NUM_COINS-1:0] w_elig;
    logic                 w_any;
    logic [SW-1:0]        w_sel;
    logic [W-1:0]         w_sel_val;
    logic                 w_start;

    function automatic logic [W-1:0] coin_val(input int k);
        case (k)
            0:       coin_val = W'(COIN_VAL0);
            1:       coin_val = W'(COIN_VAL1);
            default: coin_val = W'(COIN_VAL2);
        endcase
    endfunction

    // A coin is usable only if its tube has stock and it cannot overpay the balance.
    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_elig
            assign w_elig[gi] = !i_stock_empty[gi] && (coin_val(gi) <= r_remaining);
        end
    endgenerate

    assign w_any     = |w_elig;
    assign w_sel_val = coin_val(int'(w_sel));
    assign w_start   = (i_trigger_return || (i_wait_time == '0)) && (i_total != '0);

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (w_elig[k]) begin
                w_sel = SW'(k);
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_remaining_next   = r_remaining;
        w_return_coin_next = '0;
        w_debit_next       = 1'b0;
        w_debit_amt_next   = '0;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_residual_next    = r_residual;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_remaining_next = i_total;
                    w_state_next     = S_DISPENSE;
                    w_busy_next      = 1'b1;
                    w_residual_next  = '0;
                end
            end
            S_DISPENSE: begin
                if (!w_any) begin
                    w_state_next    = S_DONE;
                    w_residual_next = r_remaining;
                end else if (i_coin_ready) begin
                    w_return_coin_next = {{(NUM_COINS-1){1'b0}}, 1'b1} << w_sel;
                    w_debit_next       = 1'b1;
                    w_debit_amt_next   = w_sel_val;
                    w_remaining_next   = r_remaining - w_sel_val;
                end
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_return_coin <= '0;
            r_debit       <= 1'b0;
            r_debit_amt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_residual    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_remaining   <= w_remaining_next;
            r_return_coin <= w_return_coin_next;
            r_debit       <= w_debit_next;
            r_debit_amt   <= w_debit_amt_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_residual    <= w_residual_next;
        end
    end

    assign o_return_coin = r_return_coin;
    assign o_debit       = r_debit;
    assign o_debit_amt   = r_debit_amt;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_residual    = r_residual;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: greedy payout reference model feeds a scoreboard
// that a negedge monitor drains as coin pulses and done pulses appear.
module tb_change_dispenser;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_trigger_return;
    logic [31:0] i_wait_time;
    logic [31:0] i_total;
    logic [2:0]  i_stock_empty;
    logic        i_coin_ready;
    logic [2:0]  o_return_coin;
    logic        o_debit;
    logic [31:0] o_debit_amt;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_residual;

    change_dispenser dut (
        .clk              (clk),
        .reset            (reset),
        .i_trigger_return (i_trigger_return),
        .i_wait_time      (i_wait_time),
        .i_total          (i_total),
        .i_stock_empty    (i_stock_empty),
        .i_coin_ready     (i_coin_ready),
        .o_return_coin    (o_return_coin),
        .o_debit          (o_debit),
        .o_debit_amt      (o_debit_amt),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_residual       (o_residual)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int val [3]  = '{100, 500, 1000};

    int exp_coin [$];
    int exp_res  [$];
    int exp_tot  [$];
    longint acc = 0;
    int ncyc = 0;
    int last_coin_cyc = 0;
    bit coins_seen = 1'b0;
    bit last_ready = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Greedy payout with a stable stock map reduces to integer division per coin.
    function automatic void model_push(input int tot, input logic [2:0] stk);
        int rem;
        int n;
        if (tot == 0) return;
        rem = tot;
        for (int k = 2; k >= 0; k--) begin
            if (!stk[k]) begin
                n = rem / val[k];
                repeat (n) exp_coin.push_back(k);
                rem -= n * val[k];
            end
        end
        exp_res.push_back(rem);
        exp_tot.push_back(tot);
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            if (o_return_coin != 3'b000) begin
                if (exp_coin.size() == 0) begin
                    chk("unexpected_coin", longint'(o_return_coin), 0);
                end else begin
                    int k;
                    k = exp_coin.pop_front();
                    $display("coin onehot=%b amt=%0d busy=%0d", o_return_coin, o_debit_amt, o_busy);
                    chk("coin_onehot", longint'(o_return_coin), longint'(1 << k));
                    chk("coin_amt", longint'(o_debit_amt), longint'(val[k]));
                    chk("coin_debit", longint'(o_debit), 1);
                    chk("coin_busy", longint'(o_busy), 1);
                    chk("coin_ready_prev", longint'(last_ready), 1);
                    acc += o_debit_amt;
                end
                last_coin_cyc = ncyc;
                coins_seen = 1'b1;
            end else begin
                chk("debit_without_coin", longint'(o_debit), 0);
            end
            if (o_done) begin
                $display("done residual=%0d paid=%0d", o_residual, acc);
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    int r;
                    int t;
                    r = exp_res.pop_front();
                    t = exp_tot.pop_front();
                    chk("residual", longint'(o_residual), longint'(r));
                    chk("paid_plus_residual", acc + longint'(o_residual), longint'(t));
                    chk("done_busy", longint'(o_busy), 0);
                    chk("coins_left_at_done", longint'(exp_coin.size()), 0);
                    if (coins_seen) chk("done_after_last_coin", longint'(ncyc - last_coin_cyc), 2);
                end
                acc = 0;
                coins_seen = 1'b0;
            end
        end
        last_ready = i_coin_ready;
    end

    // rdy_mode: 0 ready held high, 1 random ready plus ignored-input noise, 2 ready low 3 cycles
    task automatic do_return(input int tot, input logic [2:0] stk, input bit use_timeout,
                             input int rdy_mode, input bit lat);
        int cyc;
        bit done_seen;
        @(posedge clk); #1;
        i_total       = tot;
        i_stock_empty = stk;
        i_coin_ready  = (rdy_mode == 2) ? 1'b0 : 1'b1;
        if (use_timeout) i_wait_time = 0;
        else i_trigger_return = 1'b1;
        model_push(tot, stk);
        @(posedge clk); #1;
        i_trigger_return = 1'b0;
        i_wait_time      = 100;
        if (lat) begin
            chk("lat_busy_after_start", longint'(o_busy), 1);
            chk("lat_no_coin_yet", longint'(o_return_coin), 0);
        end
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            if (rdy_mode == 1) begin
                i_coin_ready     = ($urandom_range(0, 3) != 0);
                i_trigger_return = $urandom_range(0, 1) == 1;
                i_wait_time      = ($urandom_range(0, 3) == 0) ? 0 : 100;
                i_total          = $urandom_range(1, 9999);
            end else if (rdy_mode == 2) begin
                i_coin_ready = (cyc >= 3);
            end
            @(posedge clk); #1;
            cyc++;
            if (lat && cyc == 1) chk("lat_first_coin", longint'(o_return_coin), 4);
            if (o_done) done_seen = 1'b1;
        end
        i_trigger_return = 1'b0;
        i_wait_time      = 100;
        i_coin_ready     = 1'b1;
        if (!done_seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to;
        int tot;
        bit seen;
        reset            = 1'b1;
        i_trigger_return = 1'b0;
        i_wait_time      = 100;
        i_total          = 0;
        i_stock_empty    = 3'b000;
        i_coin_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_coin", longint'(o_return_coin), 0);
        chk("rst_debit", longint'(o_debit), 0);
        chk("rst_amt", longint'(o_debit_amt), 0);
        chk("rst_busy", longint'(o_busy), 0);
        chk("rst_done", longint'(o_done), 0);
        chk("rst_residual", longint'(o_residual), 0);
        reset = 1'b0;

        // T1
        do_return(1700, 3'b000, 1'b0, 0, 1'b1);
        // T2
        @(posedge clk); #1;
        i_total = 0; i_trigger_return = 1'b1; i_wait_time = 0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("zero_total_busy", longint'(o_busy), 0);
            chk("zero_total_done", longint'(o_done), 0);
        end
        i_trigger_return = 1'b0; i_wait_time = 100;
        // T3
        @(posedge clk); #1;
        i_total = 600; i_wait_time = 2;
        @(posedge clk); #1;
        i_wait_time = 1;
        @(posedge clk); #1;
        chk("no_start_before_timeout", longint'(o_busy), 0);
        do_return(600, 3'b000, 1'b1, 0, 1'b0);
        // T4
        do_return(600, 3'b010, 1'b0, 0, 1'b0);
        do_return(750, 3'b000, 1'b0, 0, 1'b0);
        // T5
        do_return(1500, 3'b000, 1'b0, 2, 1'b0);
        // T6
        @(posedge clk); #1;
        i_total = 1700; i_trigger_return = 1'b1;
        model_push(1700, 3'b000);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_return_coin != 3'b000) seen = 1'b1;
        end
        if (!seen) chk("t6_first_coin_timeout", 0, 1);
        #1;
        reset = 1'b1;
        exp_coin.delete(); exp_res.delete(); exp_tot.delete();
        acc = 0; coins_seen = 1'b0;
        #1;
        chk("midrst_coin", longint'(o_return_coin), 0);
        chk("midrst_debit", longint'(o_debit), 0);
        chk("midrst_busy", longint'(o_busy), 0);
        chk("midrst_amt", longint'(o_debit_amt), 0);
        @(posedge clk); #1;
        i_trigger_return = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("after_midrst_idle", longint'(o_busy), 0);

        // Randomized returns with random stock, ready stalls and ignored-input noise
        for (int n = 0; n < 40; n++) begin
            tot = 50 * $urandom_range(1, 100);
            to  = $urandom_range(0, 1) == 1;
            do_return(tot, 3'($urandom_range(0, 7)), to, 1, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_coin_queue_empty", longint'(exp_coin.size()), 0);
        chk("final_done_queue_empty", longint'(exp_res.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
